arcade_input_mapper: RTL and testbench

//  Table-driven replacement for per-game hard-coded GDB input muxing. Decodes PS/2 key events,

---
 rtl/arcade_input_mapper.sv | 216 +++++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// ---------------------------------------------------------------------------
// arcade_input_mapper
//
// Table-driven input mapper placed between hps_io and an arcade game core.
// PS/2 key events and two MiSTer joysticks are merged into a 32-bit source
// vector. Each output bit of every game port is then selected from that
// vector, or forced to a constant, through a per-bit mapping table. A DIP
// byte can force any bit high. The mapping table and the DIP bytes are both
// loaded over ioctl. Coin inputs are stretched to a fixed hold time so the
// core sees a pulse long enough to register. While a mapping table is being
// downloaded, the ports keep their last value so that a half-written table
// never reaches the game.
//
// Ports
//   clk_sys         system clock
//   reset_n         asynchronous reset, active low
//   ps2_key[10:0]   [10] toggles once per key event, [9] pressed, [8:0] scan code
//   joy1, joy2      [0]R [1]L [2]D [3]U [4..7]fire A-D [8]start1 [9]start2 [10]coin
//   ioctl_download  download in progress
//   ioctl_wr        download byte strobe
//   ioctl_addr      download byte address
//   ioctl_dout      download byte
//   ioctl_index     download target index
//   port_out        NUM_PORTS registered game ports, port p at [p*8+7:p*8]
//   coin_active     high while either coin stretcher is running
//
// Mapping entry format (entry e = p*8 + b drives port p, bit b):
//   [7] invert, [6] constant mode, [5] constant value, [4:0] source index
// ---------------------------------------------------------------------------
module arcade_input_mapper #(
  parameter int          NUM_PORTS  = 3,
  parameter logic [15:0] COIN_PULSE = 16'd40000,
  parameter logic [7:0]  MAP_INDEX  = 8'd253,
  parameter logic [7:0]  DIP_INDEX  = 8'd254
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [10:0]              ps2_key,
  input  logic [15:0]              joy1,
  input  logic [15:0]              joy2,
  input  logic                     ioctl_download,
  input  logic                     ioctl_wr,
  input  logic [24:0]              ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  input  logic [7:0]               ioctl_index,
  output logic [NUM_PORTS*8-1:0]   port_out,
  output logic                     coin_active
);

  localparam int          ENTRIES   = NUM_PORTS * 8;
  localparam int          KBD_BITS  = 20;
  localparam logic [7:0]  MAP_RESET = 8'h60;

  // Keyboard bit layout matches the low 20 source bits:
  //   0-7 P1 R,L,D,U,fA-fD  8-15 P2 same  16 start1  17 start2  18 coin1  19 coin2
  // Result: [5] code recognised, [4:0] keyboard bit. The extended-code flag
  // (ps2_key[8]) is ignored so both the E0-prefixed arrows and the keypad
  // codes with the same low byte drive the same bit.
  function automatic logic [5:0] key_decode(input logic [7:0] code);
    logic [5:0] r;
    r = 6'd0;
    case (code)
      8'h74: r = {1'b1, 5'd0};
      8'h6B: r = {1'b1, 5'd1};
      8'h72: r = {1'b1, 5'd2};
      8'h75: r = {1'b1, 5'd3};
      8'h14: r = {1'b1, 5'd4};
      8'h11: r = {1'b1, 5'd5};
      8'h29: r = {1'b1, 5'd6};
      8'h12: r = {1'b1, 5'd7};
      8'h34: r = {1'b1, 5'd8};
      8'h23: r = {1'b1, 5'd9};
      8'h2B: r = {1'b1, 5'd10};
      8'h2D: r = {1'b1, 5'd11};
      8'h1C: r = {1'b1, 5'd12};
      8'h1B: r = {1'b1, 5'd13};
      8'h21: r = {1'b1, 5'd14};
      8'h1D: r = {1'b1, 5'd15};
      8'h05, 8'h16: r = {1'b1, 5'd16};
      8'h06, 8'h1E: r = {1'b1, 5'd17};
      8'h76, 8'h2E: r = {1'b1, 5'd18};
      8'h36: r = {1'b1, 5'd19};
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  // One output bit from its mapping entry, the source vector and its DIP bit.
  function automatic logic map_bit(input logic [7:0]  entry,
                                   input logic [31:0] src,
                                   input logic        dip_bit);
    logic v;
    v = entry[6] ? entry[5] : src[entry[4:0]];
    return (entry[7] ? ~v : v) | dip_bit;
  endfunction

  // ---- stage p0: PS/2 event capture and keyboard state ---------------------
  logic                ps2_tgl_p0;
  logic [KBD_BITS-1:0] kbd_p0;
  logic                ps2_event;
  logic [5:0]          key_hit;

  assign ps2_event = ps2_key[10] ^ ps2_tgl_p0;
  assign key_hit   = key_decode(ps2_key[7:0]);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_tgl_p0 <= 1'b0;
      kbd_p0     <= '0;
    end else begin
      ps2_tgl_p0 <= ps2_key[10];
      for (int i = 0; i < KBD_BITS; i++) begin
        if (ps2_event && key_hit[5] && (key_hit[4:0] == 5'(i)))
          kbd_p0[i] <= ps2_key[9];
      end
    end
  end

  // Merge keyboard with joysticks. Start and coin1 accept either stick.
  logic [7:0] p1;
  logic [7:0] p2;
  logic       start1;
  logic       start2;
  logic [1:0] coin_raw;

  assign p1          = kbd_p0[7:0]  | joy1[7:0];
  assign p2          = kbd_p0[15:8] | joy2[7:0];
  assign start1      = kbd_p0[16] | joy1[8] | joy2[8];
  assign start2      = kbd_p0[17] | joy1[9] | joy2[9];
  assign coin_raw[0] = kbd_p0[18] | joy1[10] | joy2[10];
  assign coin_raw[1] = kbd_p0[19];

  // ---- stage p0: coin stretchers --------------------------------------------
  // A rising edge only starts a pulse when the counter is idle; edges seen
  // while a pulse runs are dropped so a bouncing coin switch cannot extend it.
  logic [1:0]  coin_prev_p0;
  logic [15:0] coin_cnt_p0 [2];
  logic [1:0]  coin_str;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      coin_prev_p0 <= 2'b00;
      for (int c = 0; c < 2; c++) coin_cnt_p0[c] <= 16'd0;
    end else begin
      coin_prev_p0 <= coin_raw;
      for (int c = 0; c < 2; c++) begin
        if (coin_cnt_p0[c] != 16'd0)
          coin_cnt_p0[c] <= coin_cnt_p0[c] - 16'd1;
        else if (coin_raw[c] && !coin_prev_p0[c])
          coin_cnt_p0[c] <= COIN_PULSE;
      end
    end
  end

  assign coin_str[0] = (coin_cnt_p0[0] != 16'd0);
  assign coin_str[1] = (coin_cnt_p0[1] != 16'd0);
  assign coin_active = |coin_str;

  // Source vector: 0-7 P1, 8-15 P2, 16/17 starts, 18/19 stretched coins,
  // 20-27 either player, 28-31 zero.
  logic [31:0] src;
  assign src = {4'b0000, p1 | p2, coin_str[1], coin_str[0], start2, start1, p2, p1};

  // ---- stage p0: mapping table and DIP bytes --------------------------------
  // Address decode is an exact match per entry, so addresses past the end of
  // the table fall through without touching anything.
  logic [7:0] map_p0 [ENTRIES];
  logic [7:0] dip_p0 [NUM_PORTS];
  logic       map_wr;
  logic       dip_wr;

  assign map_wr = ioctl_wr && (ioctl_index == MAP_INDEX);
  assign dip_wr = ioctl_wr && (ioctl_index == DIP_INDEX);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < ENTRIES; e++) map_p0[e] <= MAP_RESET;
      for (int p = 0; p < NUM_PORTS; p++) dip_p0[p] <= 8'h00;
    end else begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (map_wr && (ioctl_addr == 25'(e))) map_p0[e] <= ioctl_dout;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (dip_wr && (ioctl_addr == 25'(p))) dip_p0[p] <= ioctl_dout;
      end
    end
  end

  // ---- stage p1: mapped port register ----------------------------------------
  logic [ENTRIES-1:0] port_next;
  logic               freeze;

  assign freeze = ioctl_download && (ioctl_index == MAP_INDEX);

  always_comb begin
    port_next = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int b = 0; b < 8; b++) begin
        port_next[p*8+b] = map_bit(map_p0[p*8+b], src, dip_p0[p][b]);
      end
    end
  end

  // Holding the register during a table download hides partially written
  // tables from the core; DIP downloads pass straight through.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      port_out <= '1;
    else if (!freeze)
      port_out <= port_next;
  end

  logic unused_inputs;
  assign unused_inputs = ^{joy1[15:11], joy2[15:11], ps2_key[8]};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// ---------------------------------------------------------------------------
// tb_arcade_input_mapper
//
// Directed bench for arcade_input_mapper (NUM_PORTS=3, COIN_PULSE=4).
// A behavioural model tracks key state, the mapping table, DIP bytes and coin
// pulse windows, and predicts port_out / coin_active after every rising edge.
// A compare process checks the DUT against the model on every falling edge,
// and against literal values wherever the stimulus pins one.
// ---------------------------------------------------------------------------
module tb_arcade_input_mapper;

  localparam int          NP   = 3;
  localparam int          NE   = NP * 8;
  localparam int          CP   = 4;
  localparam logic [7:0]  MAPI = 8'd253;
  localparam logic [7:0]  DIPI = 8'd254;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [10:0]   ps2_key;
  logic [15:0]   joy1;
  logic [15:0]   joy2;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic [7:0]    ioctl_index;
  logic [NE-1:0] port_out;
  logic          coin_active;

  arcade_input_mapper #(
    .NUM_PORTS (NP),
    .COIN_PULSE(16'(CP)),
    .MAP_INDEX (MAPI),
    .DIP_INDEX (DIPI)
  ) dut (
    .clk_sys       (clk),
    .reset_n       (reset_n),
    .ps2_key       (ps2_key),
    .joy1          (joy1),
    .joy2          (joy2),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_index   (ioctl_index),
    .port_out      (port_out),
    .coin_active   (coin_active)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Scan code -> source-vector bit that the key drives.
  logic [7:0] key_code [23] = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h11, 8'h29, 8'h12,
                                8'h34, 8'h23, 8'h2B, 8'h2D, 8'h1C, 8'h1B, 8'h21, 8'h1D,
                                8'h05, 8'h16, 8'h06, 8'h1E, 8'h76, 8'h2E, 8'h36};
  int         key_tgt  [23] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                                16, 16, 17, 17, 18, 18, 19};

  logic [19:0]   m_key;          // key held, indexed by source bit
  logic          m_tgl;
  logic [7:0]    m_tab [NE];
  logic [7:0]    m_dip [NP];
  int            m_edge;
  int            m_until1, m_until2;  // coin pulse visible after edges < until
  logic          m_prev1, m_prev2;
  logic [31:0]   m_s;
  logic          m_run1, m_run2, m_raw1, m_raw2, m_v;
  logic [7:0]    m_ent;
  logic [NE-1:0] exp_port;
  logic          exp_coin;

  initial begin
    m_edge = 0;
    forever begin
      @(posedge clk);
      m_edge = m_edge + 1;
      if (!reset_n) begin
        m_key = '0; m_tgl = 1'b0; m_prev1 = 1'b0; m_prev2 = 1'b0;
        for (int e = 0; e < NE; e++) m_tab[e] = 8'h60;
        for (int p = 0; p < NP; p++) m_dip[p] = 8'h00;
        m_until1 = m_edge; m_until2 = m_edge;
        exp_port = '1; exp_coin = 1'b0;
      end else begin
        m_run1 = (m_edge - 1) < m_until1;
        m_run2 = (m_edge - 1) < m_until2;
        m_s = '0;
        for (int i = 0; i < 8; i++) begin
          m_s[i]     = m_key[i]     | joy1[i];
          m_s[8 + i] = m_key[8 + i] | joy2[i];
        end
        m_s[16] = m_key[16] | joy1[8] | joy2[8];
        m_s[17] = m_key[17] | joy1[9] | joy2[9];
        m_s[18] = m_run1;
        m_s[19] = m_run2;
        for (int i = 0; i < 8; i++) m_s[20 + i] = m_s[i] | m_s[8 + i];
        if (!(ioctl_download && ioctl_index == MAPI)) begin
          for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < 8; b++) begin
              m_ent = m_tab[p*8 + b];
              m_v = m_ent[6] ? m_ent[5] : m_s[m_ent[4:0]];
              if (m_ent[7]) m_v = ~m_v;
              exp_port[p*8 + b] = m_v | m_dip[p][b];
            end
          end
        end
        m_raw1 = m_key[18] | joy1[10] | joy2[10];
        m_raw2 = m_key[19];
        if (m_raw1 && !m_prev1 && !m_run1) m_until1 = m_edge + CP;
        if (m_raw2 && !m_prev2 && !m_run2) m_until2 = m_edge + CP;
        m_prev1 = m_raw1;
        m_prev2 = m_raw2;
        exp_coin = (m_edge < m_until1) || (m_edge < m_until2);
        if (ps2_key[10] != m_tgl) begin
          m_tgl = ps2_key[10];
          for (int k = 0; k < 23; k++)
            if (key_code[k] == ps2_key[7:0]) m_key[key_tgt[k]] = ps2_key[9];
        end
        if (ioctl_wr && ioctl_index == MAPI && ioctl_addr < 25'(NE))
          m_tab[int'(ioctl_addr)] = ioctl_dout;
        if (ioctl_wr && ioctl_index == DIPI && ioctl_addr < 25'(NP))
          m_dip[int'(ioctl_addr)] = ioctl_dout;
      end
    end
  end

  // ---------------- compare process ----------------
  int            n_vec = 0;
  int            n_mis = 0;
  int            pin_req = 0;
  int            pin_done = 0;
  string         pin_tag;
  logic [NE-1:0] pin_mask, pin_val;
  bit            pin_coin_on, pin_coin_val;

  task automatic chk(input string name, input logic [NE-1:0] act, input logic [NE-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("reset_port", port_out, '1);
        chk("reset_coin", NE'(coin_active), '0);
      end else begin
        chk("model_port", port_out, exp_port);
        chk("model_coin", NE'(coin_active), NE'(exp_coin));
      end
      if (pin_req != pin_done) begin
        pin_done = pin_req;
        chk({pin_tag, "_port"}, port_out & pin_mask, pin_val);
        if (pin_coin_on) chk({pin_tag, "_coin"}, NE'(coin_active), NE'(pin_coin_val));
        if (reset_n) begin
          chk({pin_tag, "_model"}, exp_port & pin_mask, pin_val);
          if (pin_coin_on) chk({pin_tag, "_model_coin"}, NE'(exp_coin), NE'(pin_coin_val));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Literal expectation checked at the next falling edge.
  task automatic pin(input string tag, input logic [NE-1:0] mask, input logic [NE-1:0] val,
                     input bit coin_on = 1'b0, input bit coin_val = 1'b0);
    pin_tag = tag; pin_mask = mask; pin_val = val;
    pin_coin_on = coin_on; pin_coin_val = coin_val;
    pin_req++;
  endtask

  task automatic load(input logic [7:0] idx, input int addr, input logic [7:0] data);
    ioctl_download = 1'b1; ioctl_index = idx; ioctl_addr = 25'(addr);
    ioctl_dout = data; ioctl_wr = 1'b1;
    cyc();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    cyc();
  endtask

  initial begin
    reset_n = 1'b0; ps2_key = '0; joy1 = '0; joy2 = '0;
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; ioctl_index = '0;
    cyc(); cyc(); cyc();
    reset_n = 1'b1;
    pin("after_reset", '1, '1, 1'b1, 1'b0);
    cyc();

    // PS/2 right arrow through entry 0 = S0
    load(MAPI, 0, 8'h00);
    pin("map0_idle", 24'h000001, 24'h000000); cyc();
    ps2_key = {1'b1, 1'b1, 9'h074};
    pin("make_edge", 24'h000001, 24'h000000); cyc();
    pin("make_next", 24'h000001, 24'h000001); cyc();
    ps2_key = {1'b0, 1'b0, 9'h074};
    cyc();
    pin("break_next", 24'h000001, 24'h000000); cyc();

    // Inverted stretched coin1 on entry 1, second edge inside the pulse
    load(MAPI, 1, 8'h92);
    pin("coin_idle", 24'h000002, 24'h000002, 1'b1, 1'b0); cyc();
    joy2[10] = 1'b1; pin("coin_t0", 24'h000002, 24'h000002, 1'b1, 1'b1); cyc();
    joy2[10] = 1'b0; pin("coin_t1", 24'h000002, 24'h000000, 1'b1, 1'b1); cyc();
    joy2[10] = 1'b1; pin("coin_t2", 24'h000002, 24'h000000, 1'b1, 1'b1); cyc();
    joy2[10] = 1'b0; pin("coin_t3", 24'h000002, 24'h000000, 1'b1, 1'b1); cyc();
    pin("coin_t4", 24'h000002, 24'h000000, 1'b1, 1'b0); cyc();
    pin("coin_t5", 24'h000002, 24'h000002, 1'b1, 1'b0); cyc();

    // DIP forcing bit 7
    load(MAPI, 7, 8'h40);
    pin("e7_const0", 24'h000080, 24'h000000); cyc();
    load(DIPI, 0, 8'h80);
    pin("dip_force", 24'h000080, 24'h000080); cyc();
    load(MAPI, 7, 8'h40);
    pin("dip_over_map", 24'h000080, 24'h000080); cyc();

    // DIP write is visible while its download is still running
    ioctl_download = 1'b1; ioctl_index = DIPI; ioctl_addr = 25'd0;
    ioctl_dout = 8'h81; ioctl_wr = 1'b1;
    cyc();
    ioctl_wr = 1'b0;
    pin("dip_live", 24'h000081, 24'h000081); cyc();
    ioctl_download = 1'b0;
    load(DIPI, 0, 8'h80);

    // Freeze during a table download
    ioctl_download = 1'b1; ioctl_index = MAPI;
    cyc();
    joy1[0] = 1'b1;
    pin("frozen_1", 24'h000001, 24'h000000); cyc();
    pin("frozen_2", 24'h000001, 24'h000000); cyc();
    ioctl_download = 1'b0;
    pin("unfrozen", 24'h000001, 24'h000001); cyc();
    joy1[0] = 1'b0; cyc();

    // Port 1: P2 right, start1, either-player right, ~start2, P1 up
    load(MAPI, 8, 8'h08);
    load(MAPI, 9, 8'h10);
    load(MAPI, 10, 8'h14);
    load(MAPI, 11, 8'h91);
    load(MAPI, 12, 8'h03);
    joy2[0] = 1'b1; joy1[8] = 1'b1;
    pin("port1_joy", 24'h00FF00, 24'h00EF00); cyc();
    joy2[0] = 1'b0; joy1[8] = 1'b0; cyc();
    ps2_key = {1'b1, 1'b1, 9'h034}; cyc();
    pin("port1_kbd", 24'h00FF00, 24'h00ED00); cyc();
    ps2_key = {1'b0, 1'b0, 9'h034}; cyc(); cyc();

    // Out-of-range writes change nothing
    load(MAPI, NE, 8'h60);
    load(DIPI, NP, 8'hFF);
    pin("oob_writes", '1, 24'hFFE8FE); cyc();

    // Coin2 from the keyboard, then reset in the middle of the pulse
    load(MAPI, 2, 8'h13);
    ps2_key = {1'b1, 1'b1, 9'h036}; cyc();
    pin("coin2_start", 24'h000004, 24'h000000, 1'b1, 1'b1); cyc();
    pin("coin2_run", 24'h000004, 24'h000004, 1'b1, 1'b1); cyc();
    @(posedge clk);
    #1;
    reset_n = 1'b0; ps2_key = '0;
    pin("async_reset", '1, '1, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    cyc();
    reset_n = 1'b1;
    pin("table_discarded", '1, '1, 1'b1, 1'b0); cyc();
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
